// File: rtl/traffic_phase_scheduler.sv
// Demand-driven two-approach intersection sequencer: arbitrates green between UD and LR
// using synchronized presence sensors, min/max green dwell and an emergency preempt.
module traffic_phase_scheduler #(
    parameter int CLK_PER         = 10,
    parameter int TICK_CYCLES     = 100000000,
    parameter int MIN_GREEN_TICKS = 10,
    parameter int MAX_GREEN_TICKS = 30,
    parameter int YELLOW_TICKS    = 3,
    parameter int ALL_RED_TICKS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sens_ud,
    input  logic       sens_lr,
    input  logic       preempt,
    input  logic       preempt_dir,
    output logic [1:0] ud_light,
    output logic [1:0] lr_light,
    output logic       phase_change
);

    localparam int PW = $clog2(TICK_CYCLES) + 1;
    localparam int TW = $clog2(MAX_GREEN_TICKS + 1) + 1;

    // A nonsensical configuration never ticks, so the intersection stays all-red.
    localparam bit CFG_OK = (CLK_PER > 0) && (TICK_CYCLES >= 1) && (MIN_GREEN_TICKS >= 1) &&
                            (MAX_GREEN_TICKS >= MIN_GREEN_TICKS) && (YELLOW_TICKS >= 1) &&
                            (ALL_RED_TICKS >= 1);

    localparam logic       DIR_UD = 1'b0;
    localparam logic       DIR_LR = 1'b1;
    localparam logic [1:0] L_RED  = 2'd0;
    localparam logic [1:0] L_YEL  = 2'd1;
    localparam logic [1:0] L_GRN  = 2'd2;

    typedef enum logic [1:0] {
        S_ALL_RED = 2'd0,
        S_GREEN   = 2'd1,
        S_YELLOW  = 2'd2
    } state_t;

    logic [1:0] ud_ff, lr_ff, pre_ff, pdir_ff;
    logic       s_ud, s_lr, s_pre, s_pdir;

    state_t     state, state_n;
    logic       dir, dir_n;
    logic       next_dir, next_dir_n;
    logic       pend_ud, pend_lr;
    logic [PW-1:0] prescaler;
    logic [TW-1:0] timer;
    logic [TW:0]   elapsed;
    logic       tick, trans;
    logic       sens_dir, pend_other;
    logic       enter_green_ud, enter_green_lr;
    logic       ud_is_green, lr_is_green;

    function automatic logic [1:0] light_code(input state_t s, input logic d, input logic me);
        logic [1:0] code;
        code = L_RED;
        if (d == me) begin
            if (s == S_GREEN)
                code = L_GRN;
            else if (s == S_YELLOW)
                code = L_YEL;
        end
        return code;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ud_ff   <= '0;
            lr_ff   <= '0;
            pre_ff  <= '0;
            pdir_ff <= '0;
        end else begin
            ud_ff   <= {ud_ff[0], sens_ud};
            lr_ff   <= {lr_ff[0], sens_lr};
            pre_ff  <= {pre_ff[0], preempt};
            pdir_ff <= {pdir_ff[0], preempt_dir};
        end
    end

    assign s_ud   = ud_ff[1];
    assign s_lr   = lr_ff[1];
    assign s_pre  = pre_ff[1];
    assign s_pdir = pdir_ff[1];

    // elapsed is the tick count this phase will have reached after the current edge,
    // so a green of N ticks ends exactly N*TICK_CYCLES cycles after entry.
    always_comb begin
        tick       = CFG_OK && (prescaler == PW'(TICK_CYCLES - 1));
        elapsed    = {1'b0, timer} + {{TW{1'b0}}, tick};
        sens_dir   = (dir == DIR_LR) ? s_lr : s_ud;
        pend_other = (dir == DIR_LR) ? pend_ud : pend_lr;
        state_n    = state;
        dir_n      = dir;
        next_dir_n = next_dir;
        case (state)
            S_ALL_RED: begin
                if (tick && timer == TW'(ALL_RED_TICKS - 1)) begin
                    state_n = S_GREEN;
                    dir_n   = s_pre ? s_pdir : next_dir;
                end
            end
            S_GREEN: begin
                if (s_pre) begin
                    if (dir != s_pdir)
                        state_n = S_YELLOW;
                end else if (elapsed >= (TW+1)'(MIN_GREEN_TICKS) && pend_other &&
                             (!sens_dir || elapsed >= (TW+1)'(MAX_GREEN_TICKS))) begin
                    state_n = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (tick && timer == TW'(YELLOW_TICKS - 1)) begin
                    state_n    = S_ALL_RED;
                    next_dir_n = ~dir;
                end
            end
            default: state_n = S_ALL_RED;
        endcase
        trans          = (state_n != state);
        enter_green_ud = trans && state_n == S_GREEN && dir_n == DIR_UD;
        enter_green_lr = trans && state_n == S_GREEN && dir_n == DIR_LR;
        ud_is_green    = (state == S_GREEN) && (dir == DIR_UD);
        lr_is_green    = (state == S_GREEN) && (dir == DIR_LR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_ALL_RED;
            dir          <= DIR_UD;
            next_dir     <= DIR_UD;
            pend_ud      <= 1'b0;
            pend_lr      <= 1'b0;
            prescaler    <= '0;
            timer        <= '0;
            ud_light     <= L_RED;
            lr_light     <= L_RED;
            phase_change <= 1'b0;
        end else begin
            state        <= state_n;
            dir          <= dir_n;
            next_dir     <= next_dir_n;
            phase_change <= trans;
            ud_light     <= light_code(state_n, dir_n, DIR_UD);
            lr_light     <= light_code(state_n, dir_n, DIR_LR);
            if (trans) begin
                prescaler <= '0;
                timer     <= '0;
            end else begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
                if (tick && timer != TW'(MAX_GREEN_TICKS))
                    timer <= timer + 1'b1;
            end
            // Entering green for a direction wins over a same-cycle request from it.
            if (enter_green_ud)
                pend_ud <= 1'b0;
            else if (s_ud && !ud_is_green)
                pend_ud <= 1'b1;
            if (enter_green_lr)
                pend_lr <= 1'b0;
            else if (s_lr && !lr_is_green)
                pend_lr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with short timing (tick = 4 clocks,
// MIN=3, MAX=6, YELLOW=2, ALL_RED=1 ticks); light runs are measured on falling edges.
module tb_traffic_phase_scheduler;

    logic       clk;
    logic       rst;
    logic       sens_ud, sens_lr, preempt, preempt_dir;
    logic [1:0] ud_light, lr_light;
    logic       phase_change;

    int n_chk;
    int n_err;
    int pc_cnt;
    int n;
    logic [1:0] cur_ud, cur_lr;

    traffic_phase_scheduler #(
        .CLK_PER(10),
        .TICK_CYCLES(4),
        .MIN_GREEN_TICKS(3),
        .MAX_GREEN_TICKS(6),
        .YELLOW_TICKS(2),
        .ALL_RED_TICKS(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sens_ud(sens_ud),
        .sens_lr(sens_lr),
        .preempt(preempt),
        .preempt_dir(preempt_dir),
        .ud_light(ud_light),
        .lr_light(lr_light),
        .phase_change(phase_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        cur_ud = ud_light;
        cur_lr = lr_light;
        if (phase_change === 1'b1)
            pc_cnt++;
    endtask

    // sel 0: ud_light==v, sel 1: lr_light==v, sel 2: both lights RED
    function automatic bit match(input int sel, input logic [1:0] v);
        if (sel == 0)
            return cur_ud === v;
        else if (sel == 1)
            return cur_lr === v;
        else
            return (cur_ud === 2'd0) && (cur_lr === 2'd0);
    endfunction

    task automatic wait_for(input string tag, input int sel, input logic [1:0] v, input int budget);
        int k;
        k = 0;
        while (!match(sel, v) && k < budget) begin
            sample();
            k++;
        end
        chk(tag, {31'd0, match(sel, v)}, 32'd1);
    endtask

    // Counts consecutive samples (current one included) matching; leaves cur at first mismatch.
    task automatic run_len(input int sel, input logic [1:0] v, input int budget, output int len);
        len = 0;
        while (match(sel, v) && len < budget) begin
            len++;
            sample();
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        sample();
        sample();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst    = 1'b0;
        cur_ud = ud_light;
        cur_lr = lr_light;
        pc_cnt = 0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        pc_cnt = 0;
        rst = 1'b1;
        sens_ud = 1'b0;
        sens_lr = 1'b0;
        preempt = 1'b0;
        preempt_dir = 1'b0;
        sample();
        sample();

        // Reset state
        chk("rst_ud_light", ud_light, 0);
        chk("rst_lr_light", lr_light, 0);
        chk("rst_phase_change", phase_change, 0);
        chk("rst_pend_ud", dut.pend_ud, 0);
        chk("rst_pend_lr", dut.pend_lr, 0);

        // 1: no demand, UD green after one all-red tick and held
        release_reset();
        run_len(2, 2'd0, 20, n);
        chk("s1_all_red_cycles", n, 4);
        chk("s1_ud_green", cur_ud, 2);
        run_len(0, 2'd2, 200, n);
        chk("s1_ud_green_hold", n, 200);
        chk("s1_lr_red", cur_lr, 0);
        chk("s1_phase_pulses", pc_cnt, 1);

        // 2: LR demand, no UD demand -> UD leaves at MIN
        apply_reset();
        sens_lr = 1'b1;
        release_reset();
        run_len(2, 2'd0, 20, n);
        chk("s2_all_red_cycles", n, 4);
        pc_cnt = 0;
        run_len(0, 2'd2, 100, n);
        chk("s2_ud_green_cycles", n, 12);
        run_len(0, 2'd1, 100, n);
        chk("s2_ud_yellow_cycles", n, 8);
        run_len(2, 2'd0, 100, n);
        chk("s2_clear_red_cycles", n, 4);
        chk("s2_lr_green", cur_lr, 2);
        chk("s2_ud_red", cur_ud, 0);
        chk("s2_phase_pulses", pc_cnt, 3);

        // 3: both demanding -> UD held to MAX
        apply_reset();
        sens_ud = 1'b1;
        sens_lr = 1'b1;
        release_reset();
        run_len(2, 2'd0, 20, n);
        run_len(0, 2'd2, 100, n);
        chk("s3_ud_green_cycles", n, 24);
        run_len(0, 2'd1, 100, n);
        chk("s3_ud_yellow_cycles", n, 8);
        run_len(2, 2'd0, 100, n);
        chk("s3_clear_red_cycles", n, 4);
        chk("s3_lr_green", cur_lr, 2);

        // 4: preempt toward LR during early UD green
        apply_reset();
        sens_ud = 1'b0;
        sens_lr = 1'b0;
        release_reset();
        run_len(2, 2'd0, 20, n);
        repeat (4) sample();
        chk("s4_ud_green_before", cur_ud, 2);
        preempt = 1'b1;
        preempt_dir = 1'b1;
        sens_ud = 1'b1;
        run_len(0, 2'd2, 10, n);
        chk("s4_green_after_preempt", n, 3);
        chk("s4_ud_yellow", cur_ud, 1);
        run_len(0, 2'd1, 100, n);
        chk("s4_ud_yellow_cycles", n, 8);
        run_len(2, 2'd0, 100, n);
        chk("s4_clear_red_cycles", n, 4);
        run_len(1, 2'd2, 60, n);
        chk("s4_lr_green_hold", n, 60);
        chk("s4_pend_ud", dut.pend_ud, 1);
        preempt = 1'b0;
        wait_for("s4_lr_yellow_after_release", 1, 2'd1, 10);

        // 5: asynchronous reset mid-yellow
        apply_reset();
        sens_ud = 1'b0;
        sens_lr = 1'b1;
        release_reset();
        wait_for("s5_reach_ud_yellow", 0, 2'd1, 60);
        sample();
        sample();
        chk("s5_pend_lr_before", dut.pend_lr, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("s5_async_ud_light", ud_light, 0);
        chk("s5_async_lr_light", lr_light, 0);
        chk("s5_async_pend_lr", dut.pend_lr, 0);
        chk("s5_async_pend_ud", dut.pend_ud, 0);
        sens_lr = 1'b0;
        sample();
        release_reset();
        run_len(2, 2'd0, 20, n);
        chk("s5_all_red_cycles", n, 4);
        chk("s5_ud_green", cur_ud, 2);
        chk("s5_phase_pulses", pc_cnt, 1);

        // 6: LR demand pulse during UD yellow is latched and served
        apply_reset();
        release_reset();
        wait_for("s6_reach_ud_green", 0, 2'd2, 10);
        preempt = 1'b1;
        preempt_dir = 1'b1;
        wait_for("s6_reach_ud_yellow", 0, 2'd1, 10);
        preempt = 1'b0;
        chk("s6_pend_lr_idle", dut.pend_lr, 0);
        sens_lr = 1'b1;
        repeat (3) sample();
        sens_lr = 1'b0;
        repeat (2) sample();
        chk("s6_pend_lr_latched", dut.pend_lr, 1);
        wait_for("s6_reach_lr_green", 1, 2'd2, 30);
        chk("s6_pend_lr_at_entry", dut.pend_lr, 0);
        sample();
        chk("s6_pend_lr_after_entry", dut.pend_lr, 0);
        chk("s6_lr_green", cur_lr, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
